trng_sink: RTL and testbench
============================

TRNG_SINK -- requirements
Module: trng_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of 32-bit words buffered (power of two, 2..16).
REQ-002 SHALL have parameter RCT_CUTOFF, default 4, meaning the count of consecutive identical words that trips the repetition test.
REQ-003 SHALL have parameter STARTUP_WORDS, default 8, meaning the count of accepted words discarded after reset or clear.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port random_data, input, 32 bits: word from the TRNG source.
REQ-007 SHALL have port valid, input, 1 bit: random_data is valid this cycle; no backpressure is possible to the source.
REQ-008 SHALL have port clear_fail, input, 1 bit: single-cycle pulse that exits FAIL.
REQ-009 SHALL have port out_data, output, 32 bits: head-of-FIFO word.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-012 SHALL have port health_fail, output, 1 bit: sticky health-test failure.
REQ-013 SHALL have port overflow, output, 1 bit: sticky; set when a word is dropped because the FIFO is full.

Function
REQ-014 SHALL implement states STARTUP, RUN, FAIL. Transitions:
- STARTUP -> RUN after STARTUP_WORDS valid words have been counted.
- RUN -> FAIL on any health failure.
- FAIL -> STARTUP on clear_fail.
REQ-015 In STARTUP, words SHALL update the health tests but SHALL NOT enter the FIFO.
REQ-016 In RUN, a word with valid=1 SHALL be written to the FIFO in the same cycle unless the FIFO is full; a word arriving when full SHALL be dropped and SHALL set overflow.
REQ-017 Repetition count test:
- a word equal to the previous word increments rct_cnt, saturating at RCT_CUTOFF; otherwise rct_cnt resets to 1.
- rct_cnt reaching RCT_CUTOFF SHALL set health_fail on the following cycle.
REQ-018 In FAIL, words SHALL NOT be written, out_valid SHALL be 0, and the FIFO SHALL be flushed on entry.
REQ-019 out_valid SHALL equal FIFO not-empty (except in FAIL); a pop occurs when out_valid and out_ready are both 1.
REQ-020 A push and a pop in the same cycle with the FIFO full SHALL both succeed without overflow; with the FIFO empty, the word SHALL appear on out_data the next cycle (write-to-read latency is 1 cycle).
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH and use an extra wrap bit for full/empty detection.
REQ-022 clear_fail asserted together with a failure condition in the same cycle: the failure SHALL win and the state SHALL remain FAIL.
REQ-023 clear_fail SHALL reset overflow, health_fail, rct_cnt and the startup counter.

Reset
REQ-024 rst_n low SHALL asynchronously force:
- state = STARTUP
- FIFO empty
- out_valid = 0, out_data = 0
- health_fail = 0, overflow = 0
- rct_cnt = 0, startup counter = 0
REQ-025 Reset deassertion SHALL take effect on the next rising clk_in; reset mid-transfer SHALL discard the FIFO contents.

Configuration
REQ-026 Macro TRNG_SINK_APT_EN SHALL, when defined, add an adaptive proportion test on bit 0:
- window of 64 accepted words (including in STARTUP);
- count the words whose bit 0 equals bit 0 of the window's first word;
- count > 40 SHALL set health_fail at the window end.
REQ-027 Without TRNG_SINK_APT_EN, no APT logic SHALL be synthesized and behaviour SHALL be repetition test only.

Structure
REQ-028 The shared package trng_pkg SHALL hold:
- the state encoding (STARTUP=2'd0, RUN=2'd1, FAIL=2'd2);
- TRNG_WORD_W=32;
- APT_WINDOW=64 and APT_CUTOFF=40.
REQ-029 The FIFO SHALL be the sub-module trng_sync_fifo (parameterised width and depth); the health tests and state machine stay in trng_sink.

Verification
REQ-030 Reset, then 8 distinct valid words -> none output; 9th word 0xA5A5_0001 -> out_valid=1, out_data=0xA5A5_0001 one cycle later.
REQ-031 In RUN, 4 consecutive words 0xDEAD_BEEF (RCT_CUTOFF=4) -> health_fail=1 the next cycle, out_valid=0, FIFO flushed; clear_fail -> STARTUP, health_fail=0.
REQ-032 out_ready=0, 5 words with FIFO_DEPTH=4 -> 4 stored, overflow=1; then out_ready=1 -> the 4 words drain in order.
REQ-033 FIFO full, simultaneous valid and out_ready for 10 cycles -> no overflow, in-order data, count remains 4.
REQ-034 rst_n pulsed low mid-drain (asynchronous, not clock-aligned) -> out_valid=0 immediately, state=STARTUP.
REQ-035 With TRNG_SINK_APT_EN defined, 64 words all with bit0=1 and distinct values -> health_fail=1 at the window end; without the macro, the same stimulus -> health_fail=0.

Source files
------------

// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state encoding and constants for the TRNG sink
package trng_pkg;

  localparam int TRNG_WORD_W = 32;
  localparam int APT_WINDOW  = 64;
  localparam int APT_CUTOFF  = 40;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } trng_state_e;

endpackage

// File: rtl/trng_sync_fifo.sv
// rtl/trng_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and flush
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = TRNG_WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot this cycle, so a push into a full FIFO can still land.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trng_sink.sv
// rtl/trng_sink.sv - TRNG sink with startup discard, repetition count test and output FIFO
// Defining TRNG_SINK_APT_EN adds the bit-0 adaptive proportion test.
module trng_sink
  import trng_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int RCT_CUTOFF    = 4,
  parameter int STARTUP_WORDS = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic [TRNG_WORD_W-1:0] random_data,
  input  logic                   valid,
  input  logic                   clear_fail,
  output logic [TRNG_WORD_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   health_fail,
  output logic                   overflow
);

  localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
  localparam int SU_W  = $clog2(STARTUP_WORDS + 1);

  trng_state_e            state_q, state_d;
  logic [TRNG_WORD_W-1:0] prev_q, prev_d;
  logic [RCT_W-1:0]       rct_cnt_q, rct_cnt_d;
  logic [SU_W-1:0]        su_cnt_q, su_cnt_d;
  logic                   health_fail_q, health_fail_d;
  logic                   overflow_q, overflow_d;
  logic                   accept, rct_fail, apt_fail, fail_event, do_clear;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [TRNG_WORD_W-1:0] fifo_rdata;

  // Health tests watch every word outside FAIL, including the discarded startup words.
  assign accept     = valid && (state_q != ST_FAIL);
  assign fail_event = rct_fail || apt_fail;
  assign do_clear   = clear_fail && !fail_event;

  assign out_valid   = !fifo_empty && (state_q != ST_FAIL);
  assign out_data    = out_valid ? fifo_rdata : '0;
  assign fifo_pop    = out_valid && out_ready;
  assign health_fail = health_fail_q;
  assign overflow    = overflow_q;

  always_comb begin
    prev_d    = prev_q;
    rct_cnt_d = rct_cnt_q;
    rct_fail  = 1'b0;
    if (accept) begin
      prev_d = random_data;
      if ((rct_cnt_q != '0) && (random_data == prev_q))
        rct_cnt_d = (rct_cnt_q == RCT_W'(RCT_CUTOFF)) ? rct_cnt_q : rct_cnt_q + 1'b1;
      else
        rct_cnt_d = RCT_W'(1);
      rct_fail = (rct_cnt_d == RCT_W'(RCT_CUTOFF));
    end
  end

`ifdef TRNG_SINK_APT_EN
  localparam int APT_IDX_W = $clog2(APT_WINDOW);
  localparam int APT_CNT_W = $clog2(APT_WINDOW + 1);

  logic [APT_IDX_W-1:0] apt_idx_q, apt_idx_d;
  logic [APT_CNT_W-1:0] apt_cnt_q, apt_cnt_d, apt_total;
  logic                 apt_ref_q, apt_ref_d;

  always_comb begin
    apt_idx_d = apt_idx_q;
    apt_cnt_d = apt_cnt_q;
    apt_ref_d = apt_ref_q;
    apt_fail  = 1'b0;
    apt_total = apt_cnt_q + APT_CNT_W'(random_data[0] == apt_ref_q);
    if (accept) begin
      apt_idx_d = apt_idx_q + 1'b1;
      if (apt_idx_q == '0) begin
        apt_ref_d = random_data[0];
        apt_cnt_d = APT_CNT_W'(1);
      end else begin
        apt_cnt_d = apt_total;
        apt_fail  = (apt_idx_q == APT_IDX_W'(APT_WINDOW - 1)) && (apt_total > APT_CNT_W'(APT_CUTOFF));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      apt_idx_q <= '0;
      apt_cnt_q <= '0;
      apt_ref_q <= 1'b0;
    end else if (do_clear) begin
      apt_idx_q <= '0;
      apt_cnt_q <= '0;
      apt_ref_q <= 1'b0;
    end else begin
      apt_idx_q <= apt_idx_d;
      apt_cnt_q <= apt_cnt_d;
      apt_ref_q <= apt_ref_d;
    end
  end
`else
  assign apt_fail = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    su_cnt_d      = su_cnt_q;
    health_fail_d = health_fail_q;
    overflow_d    = overflow_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    if (fail_event) begin
      state_d       = ST_FAIL;
      health_fail_d = 1'b1;
      fifo_flush    = 1'b1;
    end else if (clear_fail) begin
      state_d       = ST_STARTUP;
      su_cnt_d      = '0;
      health_fail_d = 1'b0;
      overflow_d    = 1'b0;
      fifo_flush    = 1'b1;
    end else begin
      case (state_q)
        ST_STARTUP: if (valid) begin
          su_cnt_d = su_cnt_q + 1'b1;
          if (su_cnt_q == SU_W'(STARTUP_WORDS - 1)) state_d = ST_RUN;
        end
        ST_RUN: if (valid) begin
          if (fifo_full && !fifo_pop) overflow_d = 1'b1;
          else                        fifo_push  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_STARTUP;
      prev_q        <= '0;
      rct_cnt_q     <= '0;
      su_cnt_q      <= '0;
      health_fail_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      rct_cnt_q     <= do_clear ? '0 : rct_cnt_d;
      su_cnt_q      <= su_cnt_d;
      health_fail_q <= health_fail_d;
      overflow_q    <= overflow_d;
    end
  end

  trng_sync_fifo #(
    .WIDTH (TRNG_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .wdata_i (random_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_trng_sink.sv
// tb/tb_trng_sink.sv - self-checking bench for trng_sink against a queue-based reference model
module tb_trng_sink;

  localparam int DEPTH = 4;
  localparam int RCT   = 4;
  localparam int SUW   = 8;
`ifdef TRNG_SINK_APT_EN
  localparam bit APT_EN = 1'b1;
`else
  localparam bit APT_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] random_data = '0;
  logic        valid = 1'b0;
  logic        clear_fail = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, health_fail, overflow;

  int total = 0;
  int bad = 0;

  trng_sink #(.FIFO_DEPTH(DEPTH), .RCT_CUTOFF(RCT), .STARTUP_WORDS(SUW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .random_data(random_data), .valid(valid),
    .clear_fail(clear_fail), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .health_fail(health_fail), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: 0=startup 1=run 2=fail, FIFO as a queue, run length of repeated words.
  int          m_state, m_run, m_su;
  logic [31:0] m_q[$];
  logic [31:0] m_last;
  bit          m_have, m_hf, m_ov;
  bit          m_apt[$];

  function automatic void m_reset();
    m_state = 0; m_run = 0; m_su = 0; m_have = 0; m_hf = 0; m_ov = 0;
    m_q.delete(); m_apt.delete(); m_last = '0;
  endfunction

  function automatic logic m_valid();
    return (m_state != 2) && (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] m_data();
    return m_valid() ? m_q[0] : 32'h0;
  endfunction

  function automatic void m_step(input logic v, input logic [31:0] d, input logic clr, input logic rdy);
    bit pop, fail;
    int same;
    pop  = m_valid() && rdy;
    fail = 0;
    if (v && m_state != 2) begin
      m_run  = (m_have && d == m_last) ? m_run + 1 : 1;
      m_last = d;
      m_have = 1;
      if (m_run >= RCT) fail = 1;
      m_apt.push_back(d[0]);
      if (m_apt.size() == 64) begin
        same = 0;
        foreach (m_apt[k]) if (m_apt[k] == m_apt[0]) same++;
        if (APT_EN && same > 40) fail = 1;
        m_apt.delete();
      end
    end
    if (fail) begin
      m_state = 2; m_hf = 1; m_q.delete();
    end else if (clr) begin
      m_state = 0; m_hf = 0; m_ov = 0; m_have = 0; m_run = 0; m_su = 0;
      m_q.delete(); m_apt.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (v && m_state == 0) begin
        m_su++;
        if (m_su == SUW) m_state = 1;
      end else if (v && m_state == 1) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ov = 1;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic clr, input logic rdy);
    valid = v; random_data = d; clear_fail = clr; out_ready = rdy;
    m_step(v, d, clr, rdy);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_hf got=%0b exp=0", health_fail); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b exp=0", overflow); end
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_startup();
    for (int i = 0; i < SUW; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL startup_discard word=%0d got=%0b exp=0", i, out_valid); end
    end
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      bad++; $display("FAIL first_word got v=%0b d=%h exp v=1 d=a5a50001", out_valid, out_data);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL first_pop got=%0b exp=0", out_valid); end
  endtask

  task automatic test_rct();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      total++; if (health_fail !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL rct_pre rep=%0d got hf=%0b v=%0b exp hf=0 v=1", i, health_fail, out_valid);
      end
    end
    // clear_fail on the tripping word: the failure must win
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    total++; if (health_fail !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rct_trip got hf=%0b v=%0b exp hf=1 v=0", health_fail, out_valid);
    end
    drive(1'b1, $urandom, 1'b0, 1'b1);
    total++; if (health_fail !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL fail_hold got hf=%0b v=%0b exp hf=1 v=0", health_fail, out_valid);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL rct_clear got hf=%0b exp=0", health_fail); end
    for (int i = 0; i < SUW; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL restart_discard got=%0b exp=0", out_valid); end
    drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL restart_word got v=%0b d=%h exp v=1 d=0badf00d", out_valid, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w[5];
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      drive(1'b1, w[i], 1'b0, 1'b0);
      total++; if (overflow !== (i == 4)) begin
        bad++; $display("FAIL ovf_flag word=%0d got=%0b exp=%0b", i, overflow, (i == 4));
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (out_valid !== 1'b1 || out_data !== w[k]) begin
        bad++; $display("FAIL ovf_drain idx=%0d got v=%0b d=%h exp v=1 d=%h", k, out_valid, out_data, w[k]);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    total++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_end got v=%0b ov=%0b exp v=0 ov=1", out_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_clear_ov got=%0b exp=0", overflow); end
    for (int i = 0; i < SUW; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom; exp_q.push_back(w);
      drive(1'b1, w, 1'b0, 1'b0);
    end
    for (int c = 0; c < 10; c++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        bad++; $display("FAIL b2b_head cyc=%0d got v=%0b d=%h exp v=1 d=%h", c, out_valid, out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      w = $urandom; exp_q.push_back(w);
      drive(1'b1, w, 1'b0, 1'b1);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf cyc=%0d got=%0b exp=0", c, overflow); end
    end
    for (int k = 0; k < DEPTH; k++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_q[k]) begin
        bad++; $display("FAIL b2b_drain idx=%0d got v=%0b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_q[k]);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_count got v=%0b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] last = 32'h1234_5678;
    logic [31:0] d;
    logic        v, clr, rdy;
    for (int c = 0; c < 400; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 3) == 0) ? last : $urandom;
      clr = ($urandom_range(0, 63) == 0);
      rdy = $urandom_range(0, 1);
      if (v) last = d;
      drive(v, d, clr, rdy);
      total++;
      if (out_valid !== m_valid() || out_data !== m_data() || health_fail !== m_hf || overflow !== m_ov) begin
        bad++;
        $display("FAIL random cyc=%0d got v=%0b d=%h hf=%0b ov=%0b exp v=%0b d=%h hf=%0b ov=%0b",
                 c, out_valid, out_data, health_fail, overflow, m_valid(), m_data(), m_hf, m_ov);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < SUW; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid got=%0b exp=1", out_valid); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || health_fail !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL async_reset got v=%0b d=%h hf=%0b ov=%0b exp all 0", out_valid, out_data, health_fail, overflow);
    end
    #2 rst_n = 1'b1;
    m_reset();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < SUW; i++) drive(1'b1, $urandom, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_startup got=%0b exp=0", out_valid); end
    drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h5555_AAAA) begin
      bad++; $display("FAIL post_reset_run got v=%0b d=%h exp v=1 d=5555aaaa", out_valid, out_data);
    end
  endtask

  task automatic test_apt();
    valid = 1'b0; clear_fail = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_reset();
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, ($urandom & 32'hFFFF_FF00) | 32'(i * 2 + 1), 1'b0, 1'b1);
      if (i == 62) begin
        total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL apt_early got=%0b exp=0", health_fail); end
      end
    end
    total++; if (health_fail !== APT_EN) begin
      bad++; $display("FAIL apt_window got=%0b exp=%0b", health_fail, APT_EN);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_startup();
    test_rct();
    test_overflow();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_apt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
